// File: rtl/regfile_pkg.sv
// Shared constants for the register-bank writeback path.
// Requester indices double as bit positions in the arbiter request/grant vectors.
package regfile_pkg;

  localparam int unsigned DEF_DATA_WIDTH     = 32;
  localparam int unsigned DEF_REG_ADDR_WIDTH = 5;
  localparam int unsigned ZERO_REG           = 0;
  localparam int unsigned REQ_ALU            = 0;
  localparam int unsigned REQ_LSU            = 1;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-requester round-robin arbiter with a one-hot combinational grant.
// last_grant records the most recent winner; reset value 1 lets requester 0 win first.
module rr_arbiter2 (
  input  logic       clk,
  input  logic       rst,
  input  logic       hold,
  input  logic [1:0] req,
  output logic [1:0] gnt
);

  logic last_grant_q, last_grant_d;

  always_comb begin
    gnt          = 2'b00;
    last_grant_d = last_grant_q;
    if (!hold) begin
      if (req == 2'b11) begin
        // Under contention the requester that did not win last time goes next.
        gnt = last_grant_q ? 2'b01 : 2'b10;
      end else begin
        gnt = req;
      end
    end
    if (gnt != 2'b00) begin
      last_grant_d = gnt[1];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_grant_q <= 1'b1;
    end else begin
      last_grant_q <= last_grant_d;
    end
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Arbitrates ALU and LSU writeback onto the single register-bank write port
// through a registered output stage; x0 writes complete their handshake but never assert we.
module regfile_wb_arbiter
  import regfile_pkg::*;
#(
  parameter int unsigned DATA_WIDTH     = DEF_DATA_WIDTH,
  parameter int unsigned REG_ADDR_WIDTH = DEF_REG_ADDR_WIDTH,
  parameter int unsigned CNT_WIDTH      = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      hold,
  input  logic                      req0_valid,
  input  logic [REG_ADDR_WIDTH-1:0] req0_addr,
  input  logic [DATA_WIDTH-1:0]     req0_data,
  output logic                      req0_ready,
  input  logic                      req1_valid,
  input  logic [REG_ADDR_WIDTH-1:0] req1_addr,
  input  logic [DATA_WIDTH-1:0]     req1_data,
  output logic                      req1_ready,
  output logic                      we,
  output logic [REG_ADDR_WIDTH-1:0] wa,
  output logic [DATA_WIDTH-1:0]     wd,
  output logic [CNT_WIDTH-1:0]      conflict_cnt
);

  logic [1:0]                gnt;
  logic [REG_ADDR_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0]     sel_data;
  logic                      contention;
  logic                      we_q;
  logic [REG_ADDR_WIDTH-1:0] wa_q;
  logic [DATA_WIDTH-1:0]     wd_q;
  logic [CNT_WIDTH-1:0]      cnt_q;

  rr_arbiter2 u_arb (
    .clk  (clk),
    .rst  (rst),
    .hold (hold),
    .req  ({req1_valid, req0_valid}),
    .gnt  (gnt)
  );

  assign req0_ready = gnt[REQ_ALU];
  assign req1_ready = gnt[REQ_LSU];
  assign sel_addr   = gnt[REQ_LSU] ? req1_addr : req0_addr;
  assign sel_data   = gnt[REQ_LSU] ? req1_data : req0_data;
  assign contention = req0_valid & req1_valid & ~hold;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      we_q <= 1'b0;
      wa_q <= '0;
      wd_q <= '0;
    end else if (gnt != 2'b00) begin
      we_q <= (sel_addr != REG_ADDR_WIDTH'(ZERO_REG));
      wa_q <= sel_addr;
      wd_q <= sel_data;
    end else begin
      we_q <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (contention && (cnt_q != '1)) begin
      cnt_q <= cnt_q + CNT_WIDTH'(1);
    end
  end

  assign we           = we_q;
  assign wa           = wa_q;
  assign wd           = wd_q;
  assign conflict_cnt = cnt_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter with a simple register-bank model fed from we/wa/wd.
// A second instance with a 4-bit counter shares all inputs to exercise saturation.
module tb_regfile_wb_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        hold = 1'b0;
  logic        req0_valid = 1'b0;
  logic [4:0]  req0_addr = '0;
  logic [31:0] req0_data = '0;
  logic        req0_ready;
  logic        req1_valid = 1'b0;
  logic [4:0]  req1_addr = '0;
  logic [31:0] req1_data = '0;
  logic        req1_ready;
  logic        we;
  logic [4:0]  wa;
  logic [31:0] wd;
  logic [15:0] conflict_cnt;
  logic        s_req0_ready, s_req1_ready, s_we;
  logic [4:0]  s_wa;
  logic [31:0] s_wd;
  logic [3:0]  s_conflict_cnt;

  int compared = 0;
  int mismatched = 0;

  logic [31:0] bank [32] = '{default: '0};

  always #5 clk = ~clk;

  regfile_wb_arbiter #(.DATA_WIDTH(32), .REG_ADDR_WIDTH(5), .CNT_WIDTH(16)) dut (
    .clk(clk), .rst(rst), .hold(hold),
    .req0_valid(req0_valid), .req0_addr(req0_addr), .req0_data(req0_data), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_addr(req1_addr), .req1_data(req1_data), .req1_ready(req1_ready),
    .we(we), .wa(wa), .wd(wd), .conflict_cnt(conflict_cnt)
  );

  regfile_wb_arbiter #(.DATA_WIDTH(32), .REG_ADDR_WIDTH(5), .CNT_WIDTH(4)) dut_sat (
    .clk(clk), .rst(rst), .hold(hold),
    .req0_valid(req0_valid), .req0_addr(req0_addr), .req0_data(req0_data),
    .req0_ready(s_req0_ready),
    .req1_valid(req1_valid), .req1_addr(req1_addr), .req1_data(req1_data),
    .req1_ready(s_req1_ready),
    .we(s_we), .wa(s_wa), .wd(s_wd), .conflict_cnt(s_conflict_cnt)
  );

  always @(posedge clk) begin
    if (we) bank[wa] <= wd;
  end

  // Requester-protocol monitor: an ungranted request must be re-presented unchanged.
  logic        p0_v = 1'b0, p0_r = 1'b0, p1_v = 1'b0, p1_r = 1'b0;
  logic [4:0]  p0_a, p1_a;
  logic [31:0] p0_d, p1_d;
  always @(negedge clk) begin
    if (rst) begin
      p0_v = 1'b0;
      p1_v = 1'b0;
    end else begin
      if (p0_v && !p0_r) begin
        compared++;
        if (!req0_valid || req0_addr !== p0_a || req0_data !== p0_d) begin
          mismatched++;
          $display("FAIL req0_protocol: valid=%0b addr=%0d data=%h required valid=1 addr=%0d data=%h",
                   req0_valid, req0_addr, req0_data, p0_a, p0_d);
        end
      end
      if (p1_v && !p1_r) begin
        compared++;
        if (!req1_valid || req1_addr !== p1_a || req1_data !== p1_d) begin
          mismatched++;
          $display("FAIL req1_protocol: valid=%0b addr=%0d data=%h required valid=1 addr=%0d data=%h",
                   req1_valid, req1_addr, req1_data, p1_a, p1_d);
        end
      end
      p0_v = req0_valid; p0_r = req0_ready; p0_a = req0_addr; p0_d = req0_data;
      p1_v = req1_valid; p1_r = req1_ready; p1_a = req1_addr; p1_d = req1_data;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    hold = 1'b0;
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    step();
  endtask

  task automatic test_reset();
    do_reset();
    compared++;
    if (we !== 1'b0 || wa !== 5'd0 || wd !== 32'd0 || conflict_cnt !== 16'd0) begin
      mismatched++;
      $display("FAIL reset_idle: we=%0b wa=%0d wd=%h cnt=%0d required 0/0/0/0", we, wa, wd, conflict_cnt);
    end
    // Run two contended cycles, then hit reset mid-cycle.
    req0_valid = 1'b1; req0_addr = 5'd7; req0_data = 32'h7777_0000;
    req1_valid = 1'b1; req1_addr = 5'd8; req1_data = 32'h8888_0000;
    step();
    step();
    #2;
    rst = 1'b1;
    #1;
    compared++;
    if (we !== 1'b0 || wa !== 5'd0 || wd !== 32'd0 || conflict_cnt !== 16'd0) begin
      mismatched++;
      $display("FAIL reset_async: we=%0b wa=%0d wd=%h cnt=%0d required 0/0/0/0", we, wa, wd, conflict_cnt);
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    step();
    rst = 1'b0;
    step();
    compared++;
    if (we !== 1'b0) begin
      mismatched++;
      $display("FAIL reset_no_write: we=%0b required 0", we);
    end
  endtask

  task automatic test_contention();
    req0_valid = 1'b1; req0_addr = 5'd1; req0_data = 32'hA1A1_A1A1;
    req1_valid = 1'b1; req1_addr = 5'd2; req1_data = 32'hB2B2_B2B2;
    for (int i = 0; i < 4; i++) begin
      #1;
      compared++;
      if ({req1_ready, req0_ready} !== ((i % 2 == 0) ? 2'b01 : 2'b10)) begin
        mismatched++;
        $display("FAIL contention_grant[%0d]: ready=%b required %b", i, {req1_ready, req0_ready},
                 (i % 2 == 0) ? 2'b01 : 2'b10);
      end
      step();
      compared++;
      if (we !== 1'b1 || wa !== ((i % 2 == 0) ? 5'd1 : 5'd2)) begin
        mismatched++;
        $display("FAIL contention_write[%0d]: we=%0b wa=%0d required we=1 wa=%0d", i, we, wa,
                 (i % 2 == 0) ? 1 : 2);
      end
    end
    compared++;
    if (conflict_cnt !== 16'd4) begin
      mismatched++;
      $display("FAIL contention_count: cnt=%0d required 4", conflict_cnt);
    end
    // req0 still pending; let it finish alone.
    req1_valid = 1'b0;
    step();
    req0_valid = 1'b0;
    step();
    compared++;
    if (bank[1] !== 32'hA1A1_A1A1 || bank[2] !== 32'hB2B2_B2B2 || conflict_cnt !== 16'd4) begin
      mismatched++;
      $display("FAIL contention_bank: x1=%h x2=%h cnt=%0d required a1a1a1a1 b2b2b2b2 4",
               bank[1], bank[2], conflict_cnt);
    end
  endtask

  task automatic test_single();
    req0_valid = 1'b1; req0_addr = 5'd5; req0_data = 32'hDEAD_BEEF;
    #1;
    compared++;
    if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
      mismatched++;
      $display("FAIL single_ready: ready0=%0b ready1=%0b required 1 0", req0_ready, req1_ready);
    end
    step();
    req0_valid = 1'b0;
    compared++;
    if (we !== 1'b1 || wa !== 5'd5 || wd !== 32'hDEAD_BEEF) begin
      mismatched++;
      $display("FAIL single_write: we=%0b wa=%0d wd=%h required 1 5 deadbeef", we, wa, wd);
    end
    step();
    compared++;
    if (bank[5] !== 32'hDEAD_BEEF || we !== 1'b0) begin
      mismatched++;
      $display("FAIL single_bank: x5=%h we=%0b required deadbeef 0", bank[5], we);
    end
  endtask

  task automatic test_x0();
    req1_valid = 1'b1; req1_addr = 5'd0; req1_data = 32'h1234_5678;
    #1;
    compared++;
    if (req1_ready !== 1'b1) begin
      mismatched++;
      $display("FAIL x0_ready: ready1=%0b required 1", req1_ready);
    end
    step();
    req1_valid = 1'b0;
    compared++;
    if (we !== 1'b0 || wa !== 5'd0 || wd !== 32'h1234_5678) begin
      mismatched++;
      $display("FAIL x0_write: we=%0b wa=%0d wd=%h required 0 0 12345678", we, wa, wd);
    end
    step();
    compared++;
    if (bank[0] !== 32'd0) begin
      mismatched++;
      $display("FAIL x0_bank: x0=%h required 0", bank[0]);
    end
  endtask

  task automatic test_hold();
    do_reset();
    hold = 1'b1;
    req0_valid = 1'b1; req0_addr = 5'd3; req0_data = 32'h3333_3333;
    req1_valid = 1'b1; req1_addr = 5'd4; req1_data = 32'h4444_4444;
    for (int i = 0; i < 3; i++) begin
      #1;
      compared++;
      if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
        mismatched++;
        $display("FAIL hold_ready[%0d]: ready0=%0b ready1=%0b required 0 0", i, req0_ready, req1_ready);
      end
      step();
      compared++;
      if (we !== 1'b0 || conflict_cnt !== 16'd0) begin
        mismatched++;
        $display("FAIL hold_idle[%0d]: we=%0b cnt=%0d required 0 0", i, we, conflict_cnt);
      end
    end
    hold = 1'b0;
    #1;
    compared++;
    if ({req1_ready, req0_ready} !== 2'b01) begin
      mismatched++;
      $display("FAIL hold_release: ready=%b required 01", {req1_ready, req0_ready});
    end
    step();
    compared++;
    if (we !== 1'b1 || wa !== 5'd3 || conflict_cnt !== 16'd1) begin
      mismatched++;
      $display("FAIL hold_release_write: we=%0b wa=%0d cnt=%0d required 1 3 1", we, wa, conflict_cnt);
    end
    req0_valid = 1'b0;
    step();
    req1_valid = 1'b0;
    compared++;
    if (we !== 1'b1 || wa !== 5'd4) begin
      mismatched++;
      $display("FAIL hold_lsu_write: we=%0b wa=%0d required 1 4", we, wa);
    end
  endtask

  task automatic test_saturation();
    do_reset();
    req0_valid = 1'b1; req0_addr = 5'd9;  req0_data = 32'h9999_0000;
    req1_valid = 1'b1; req1_addr = 5'd10; req1_data = 32'hAAAA_0000;
    for (int i = 0; i < 20; i++) begin
      step();
      if (i == 14) begin
        compared++;
        if (s_conflict_cnt !== 4'd15) begin
          mismatched++;
          $display("FAIL sat_reach: cnt4=%0d required 15", s_conflict_cnt);
        end
      end
    end
    compared++;
    if (s_conflict_cnt !== 4'd15 || conflict_cnt !== 16'd20) begin
      mismatched++;
      $display("FAIL sat_hold: cnt4=%0d cnt16=%0d required 15 20", s_conflict_cnt, conflict_cnt);
    end
    req1_valid = 1'b0;
    step();
    req0_valid = 1'b0;
    step();
  endtask

  initial begin
    test_reset();
    test_contention();
    test_single();
    test_x0();
    test_hold();
    test_saturation();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
